pc_update: RTL and testbench
============================

PC_UPDATE -- requirements
Module: pc_update

Interface
- REQ-001 SHALL have one clock; reset is synchronous and active-low.
- REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
- REQ-003 SHALL have port CLK, input, 1: rising-edge clock.
- REQ-004 SHALL have port RESET, input, 1: synchronous, active-low.
- REQ-005 SHALL have port BRANCH_TAKEN, input, 1: EX-stage branch/jump decision from branch_select.
- REQ-006 SHALL have port BRANCH_TARGET, input, 32: EX-stage target address (ALU result).
- REQ-007 SHALL have port HAZARD_STALL, input, 1: load-use stall from the hazard unit.
- REQ-008 SHALL have port IMEM_BUSY, input, 1: instruction memory cannot accept a new fetch address.
- REQ-009 SHALL have port PC, output, 32: current fetch address, registered.
- REQ-010 SHALL have port PC_PLUS_4, output, 32: PC+4, combinational from PC.
- REQ-011 SHALL have port INSTR_VALID, output, 1: the fetch at PC this cycle is live, registered.
- REQ-012 SHALL have port FLUSH_IF_ID, output, 1: squash the IF/ID register, registered.
- REQ-013 SHALL have port FLUSH_ID_EX, output, 1: squash the ID/EX register, registered.
- REQ-014 SHALL have port MISALIGNED, output, 1: the redirect target had bit 1 set, registered.

Function
- REQ-015 SHALL implement a two-state FSM: RUN and REDIRECT.
- REQ-016 SHALL sample all inputs at the rising edge of CLK; every registered output updates at that edge.
- REQ-017 In RUN with BRANCH_TAKEN=0, HAZARD_STALL=0 and IMEM_BUSY=0, PC SHALL load PC+4 and INSTR_VALID SHALL be 1.
- REQ-018 In RUN with BRANCH_TAKEN=0 and either HAZARD_STALL or IMEM_BUSY high, PC SHALL hold.
- REQ-019 In the case of REQ-018, INSTR_VALID SHALL equal NOT IMEM_BUSY.
- REQ-020 In RUN with BRANCH_TAKEN=1, the redirect address SHALL be {BRANCH_TARGET[31:1],1'b0}.
- REQ-021 BRANCH_TAKEN SHALL take priority over HAZARD_STALL.
- REQ-022 In RUN with BRANCH_TAKEN=1 and IMEM_BUSY=0, PC SHALL load the redirect address, INSTR_VALID SHALL be 1, and the FSM SHALL stay in RUN.
- REQ-023 In RUN with BRANCH_TAKEN=1 and IMEM_BUSY=1, the redirect address SHALL be latched into a pending register, PC SHALL hold, INSTR_VALID SHALL be 0, and the FSM SHALL enter REDIRECT.
- REQ-024 In REDIRECT, BRANCH_TAKEN and HAZARD_STALL SHALL be ignored, since they come from squashed instructions.
- REQ-025 In REDIRECT, PC SHALL load the pending address and the FSM SHALL return to RUN on the first edge with IMEM_BUSY=0; INSTR_VALID SHALL be 0 until that edge.
- REQ-026 FLUSH_IF_ID and FLUSH_ID_EX SHALL each be a pulse of exactly one cycle, following every edge at which BRANCH_TAKEN=1 is accepted in RUN.
- REQ-027 MISALIGNED SHALL be a one-cycle pulse when BRANCH_TARGET[1]=1 at acceptance; the redirect SHALL still proceed.
- REQ-028 Latency SHALL be one cycle: BRANCH_TAKEN sampled at edge N makes the redirect address visible on PC after edge N when IMEM_BUSY=0, and flushes high during cycle N+1.
- REQ-029 PC+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.

Reset
- REQ-030 With RESET=0 at an edge: PC=RESET_VECTOR, FSM=RUN, pending register=0.
- REQ-031 With RESET=0 at an edge: INSTR_VALID, FLUSH_IF_ID, FLUSH_ID_EX and MISALIGNED SHALL all be 0.
- REQ-032 Reset SHALL override everything, including a pending REDIRECT, which is discarded.
- REQ-033 On the first edge with RESET=1, fetch SHALL begin at RESET_VECTOR with INSTR_VALID=1, provided IMEM_BUSY=0.

Structure
- REQ-034 The shared header pc_defs SHALL hold the FSM state encodings, the default RESET_VECTOR and the instruction width constant (4).
- REQ-035 One sub-module SHALL be used: pc_adder, a 32-bit +4 incrementer that drives PC_PLUS_4 and the RUN next-PC.
- REQ-036 All other logic SHALL be flat in pc_update, with no latches.

Verification
- REQ-037 Reset release, IMEM_BUSY=0, 4 edges -> PC sequence 0x0, 0x4, 0x8, 0xC, 0x10; INSTR_VALID=1 after the first edge.
- REQ-038 At PC=0x40, BRANCH_TAKEN=1 with BRANCH_TARGET=0x101 -> next PC=0x100, FLUSH_IF_ID=FLUSH_ID_EX=1 for one cycle, MISALIGNED=0.
- REQ-039 BRANCH_TAKEN=1, BRANCH_TARGET=0x200, IMEM_BUSY=1 for 3 cycles, BRANCH_TAKEN=1 with target 0x300 during the wait -> PC holds, INSTR_VALID=0, then PC=0x200; 0x300 is never loaded.
- REQ-040 HAZARD_STALL=1 for 2 cycles at PC=0x20 -> PC stays 0x20, INSTR_VALID=1; with BRANCH_TAKEN=1 (target 0x80) on the same edge -> PC=0x80.
- REQ-041 Set PC to 0xFFFF_FFFC via redirect, then advance one edge -> PC=0x0000_0000; redirect to 0x102 -> MISALIGNED pulse, PC=0x102.
- REQ-042 RESET=0 asserted while in REDIRECT -> PC=RESET_VECTOR, FSM=RUN, no stale redirect after release.

Source files
------------

// File: rtl/pc_update_pkg.sv
// Shared definitions for the fetch PC block: FSM state encodings, the default
// reset vector, the instruction width and the redirect alignment helper.
package pc_update_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES         = 4;

    // Redirect targets come from the ALU; bit 0 is forced low (JALR semantics).
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return target & ~32'h0000_0001;
    endfunction

endpackage

// File: rtl/pc_update_adder.sv
// Sequential-fetch incrementer: advances the PC by one instruction, wrapping mod 2^32.
module pc_adder
    import pc_update_pkg::*;
(
    input  logic [31:0] pc_i,
    output logic [31:0] pc_plus_4_o
);

    assign pc_plus_4_o = pc_i + 32'(INSTR_BYTES);

endmodule

// File: rtl/pc_update.sv
// Fetch program counter with branch redirect, stall handling and a pending
// redirect state for when instruction memory is busy.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   ST_RUN      | normal fetch: advance, hold on stall/busy, or take a redirect
//   ST_REDIRECT | redirect accepted while imem busy; wait to load pending addr
module pc_update
    import pc_update_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        HAZARD_STALL,
    input  logic        IMEM_BUSY,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS_4,
    output logic        INSTR_VALID,
    output logic        FLUSH_IF_ID,
    output logic        FLUSH_ID_EX,
    output logic        MISALIGNED
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] pc_plus_4;
    logic [31:0] redirect_addr;

    pc_adder u_pc_adder (
        .pc_i        (pc_q),
        .pc_plus_4_o (pc_plus_4)
    );

    assign redirect_addr = align_target(BRANCH_TARGET);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_VECTOR;
            pending_q    <= 32'h0000_0000;
            valid_q      <= 1'b0;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            valid_q      <= valid_d;
            flush_q      <= flush_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = pending_q;
        valid_d      = 1'b0;
        flush_d      = 1'b0;
        misaligned_d = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (BRANCH_TAKEN) begin
                    // Branch wins over a load-use stall; the stalled instruction is squashed.
                    flush_d      = 1'b1;
                    misaligned_d = BRANCH_TARGET[1];
                    if (IMEM_BUSY) begin
                        pending_d = redirect_addr;
                        state_d   = ST_REDIRECT;
                    end else begin
                        pc_d    = redirect_addr;
                        valid_d = 1'b1;
                    end
                end else if (HAZARD_STALL || IMEM_BUSY) begin
                    valid_d = !IMEM_BUSY;
                end else begin
                    pc_d    = pc_plus_4;
                    valid_d = 1'b1;
                end
            end
            ST_REDIRECT: begin
                // Branch/stall inputs here belong to squashed instructions.
                if (!IMEM_BUSY) begin
                    pc_d    = pending_q;
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign PC          = pc_q;
    assign PC_PLUS_4   = pc_plus_4;
    assign INSTR_VALID = valid_q;
    assign FLUSH_IF_ID = flush_q;
    assign FLUSH_ID_EX = flush_q;
    assign MISALIGNED  = misaligned_q;

endmodule

// File: tb/tb_pc_update.sv
// Directed bench for pc_update: sequential fetch, redirects, stalls, busy
// redirect handling, wrap-around and reset during a pending redirect.
module tb_pc_update;

    logic        CLK;
    logic        RESET;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        HAZARD_STALL;
    logic        IMEM_BUSY;
    logic [31:0] PC;
    logic [31:0] PC_PLUS_4;
    logic        INSTR_VALID;
    logic        FLUSH_IF_ID;
    logic        FLUSH_ID_EX;
    logic        MISALIGNED;

    int n_tests = 0;
    int n_fail  = 0;

    pc_update dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .HAZARD_STALL  (HAZARD_STALL),
        .IMEM_BUSY     (IMEM_BUSY),
        .PC            (PC),
        .PC_PLUS_4     (PC_PLUS_4),
        .INSTR_VALID   (INSTR_VALID),
        .FLUSH_IF_ID   (FLUSH_IF_ID),
        .FLUSH_ID_EX   (FLUSH_ID_EX),
        .MISALIGNED    (MISALIGNED)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] exp_pc, input logic exp_valid,
                               input logic exp_flush, input logic exp_mis);
        check_eq({tag, ".pc"},     PC,                 exp_pc);
        check_eq({tag, ".pc4"},    PC_PLUS_4,          exp_pc + 32'd4);
        check_eq({tag, ".valid"},  32'(INSTR_VALID),   32'(exp_valid));
        check_eq({tag, ".fl_ifid"},32'(FLUSH_IF_ID),   32'(exp_flush));
        check_eq({tag, ".fl_idex"},32'(FLUSH_ID_EX),   32'(exp_flush));
        check_eq({tag, ".mis"},    32'(MISALIGNED),    32'(exp_mis));
    endtask

    task automatic drive(input logic bt, input logic [31:0] tgt, input logic stall, input logic busy);
        BRANCH_TAKEN  = bt;
        BRANCH_TARGET = tgt;
        HAZARD_STALL  = stall;
        IMEM_BUSY     = busy;
    endtask

    initial begin
        RESET = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset state
        tick(); tick();
        check_state("reset", 32'h0, 1'b0, 1'b0, 1'b0);

        // Sequential fetch from the reset vector up to 0x40
        RESET = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_state("seq", 32'(i * 4), 1'b1, 1'b0, 1'b0);
        end

        // Redirect with bit 0 set: aligned down, flushes for one cycle
        drive(1'b1, 32'h0000_0101, 1'b0, 1'b0);
        tick();
        check_state("br101", 32'h100, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check_state("br101_after", 32'h104, 1'b1, 1'b0, 1'b0);

        // Hazard stall at 0x20, then a branch on a stalled edge wins
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        tick();
        check_state("to20", 32'h20, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check_state("stall1", 32'h20, 1'b1, 1'b0, 1'b0);
        tick();
        check_state("stall2", 32'h20, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h80, 1'b1, 1'b0);
        tick();
        check_state("stall_br", 32'h80, 1'b1, 1'b1, 1'b0);

        // IMEM busy without a branch: hold, fetch not live
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check_state("busy_hold", 32'h80, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check_state("busy_rel", 32'h84, 1'b1, 1'b0, 1'b0);

        // Redirect while busy; later branch during the wait is ignored
        drive(1'b1, 32'h200, 1'b0, 1'b1);
        tick();
        check_state("pend_acc", 32'h84, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 32'h300, 1'b0, 1'b1);
        tick();
        check_state("pend_w1", 32'h84, 1'b0, 1'b0, 1'b0);
        tick();
        check_state("pend_w2", 32'h84, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h300, 1'b1, 1'b0);
        tick();
        check_state("pend_load", 32'h200, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check_state("pend_next", 32'h204, 1'b1, 1'b0, 1'b0);

        // Wrap-around and a misaligned target
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        tick();
        check_state("to_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        check_eq("wrap.pc4", PC_PLUS_4, 32'h0000_0000);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check_state("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h102, 1'b0, 1'b0);
        tick();
        check_state("mis", 32'h102, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check_state("mis_after", 32'h106, 1'b1, 1'b0, 1'b0);

        // Reset while a redirect is pending discards it
        drive(1'b1, 32'h500, 1'b0, 1'b1);
        tick();
        check_state("pend2", 32'h106, 1'b0, 1'b1, 1'b0);
        RESET = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check_state("rst_pend", 32'h0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check_state("rst_rel", 32'h4, 1'b1, 1'b0, 1'b0);
        tick();
        check_state("rst_rel2", 32'h8, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
